// File: rtl/lfsr_bist_pkg.sv
// lfsr_bist_pkg
// Shared types, constants and helper functions for the LFSR memory BIST.
//   bist_state_t : controller state encoding
//   LFSR_W       : LFSR width
//   LFSR_TAPS    : feedback tap mask (bits 15, 13, 12, 10)
//   DEFAULT_SEED : default LFSR load value
//   lfsr_next()  : one Fibonacci advance
//   safe_seed()  : replaces the all-zero lock-up seed
package lfsr_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } bist_state_t;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

  // Shift left, feed back the XOR of the tapped bits into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

  // An all-zero state never leaves zero, so it is swapped for 1.
  function automatic logic [LFSR_W-1:0] safe_seed(input logic [LFSR_W-1:0] s);
    if (s == 16'h0000) begin
      return 16'h0001;
    end else begin
      return s;
    end
  endfunction

endpackage

// File: rtl/lfsr_bist_if.sv
// lfsr_bist_if
// Single-port bit-memory bus between the BIST initiator and the memory.
//   data_a : write data bit
//   addr_a : address
//   we_a   : write enable
//   q_a    : registered read data (valid one cycle after the address, we_a=0)
// Modports: master = BIST side, slave = memory side.
interface lfsr_bist_if #(
  parameter int ADDR_W = 11
);

  logic              data_a;
  logic [ADDR_W-1:0] addr_a;
  logic              we_a;
  logic              q_a;

  modport master (output data_a, output addr_a, output we_a, input q_a);
  modport slave  (input data_a, input addr_a, input we_a, output q_a);

endinterface

// File: rtl/lfsr_bist_lfsr16.sv
// lfsr16
// 16-bit Fibonacci LFSR used for both generating and regenerating the
// test pattern; the controller reloads it at the start of every phase.
//   clk     : clock, rising edge
//   load    : load seed (has priority over step)
//   seed    : load value
//   step    : advance one position
//   bit_out : current MSB, i.e. the bit emitted before the next advance
module lfsr16
  import lfsr_bist_pkg::*;
(
  input  logic              clk,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic              bit_out
);

  logic [LFSR_W-1:0] state_r;

  // LFSR state register: load wins over step, otherwise hold.
  always_ff @(posedge clk) begin
    if (load) begin
      state_r <= seed;
    end else if (step) begin
      state_r <= lfsr_next(state_r);
    end else begin
      state_r <= state_r;
    end
  end

  assign bit_out = state_r[LFSR_W-1];

endmodule

// File: rtl/lfsr_bist.sv
// lfsr_bist
// BIST initiator for a 2^ADDR_W x 1 single-port memory. Writes an LFSR
// pattern to every address, reads it back and compares against a
// regenerated copy; optionally repeats with inverted data.
//   clk, rst       : clock and synchronous active-high reset
//   start          : request, honoured only in IDLE or DONE
//   busy           : test running
//   done           : level, test finished
//   pass           : no mismatches (valid while done)
//   err_count      : saturating mismatch count over all passes
//   first_err_addr : address of the first mismatch (0 if none)
//   mem            : memory bus (master side)
module lfsr_bist
  import lfsr_bist_pkg::*;
#(
  parameter int              ADDR_W   = 11,
  parameter logic [LFSR_W-1:0] SEED   = DEFAULT_SEED,
  parameter bit              TWO_PASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  lfsr_bist_if.master       mem
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   ERR_MAX   = {(ADDR_W+1){1'b1}};
  localparam logic [ADDR_W:0]   ERR_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   ERR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [LFSR_W-1:0] SEED_EFF  = safe_seed(SEED);

  bist_state_t       state_r;
  logic              busy_r;
  logic              done_r;
  logic              pass_r;
  logic [ADDR_W:0]   err_count_r;
  logic [ADDR_W-1:0] first_err_addr_r;
  logic              first_seen_r;
  logic              data_a_r;
  logic [ADDR_W-1:0] addr_a_r;
  logic              we_a_r;
  logic              inv_r;
  logic              pipe_v_r;
  logic              pipe_exp_r;
  logic [ADDR_W-1:0] pipe_addr_r;

  logic              lfsr_load_s;
  logic              lfsr_step_s;
  logic              lfsr_bit_s;
  logic              exp_bit_s;
  logic              last_addr_s;
  logic              mismatch_s;
  logic [ADDR_W:0]   err_next_s;
  logic [ADDR_W-1:0] first_next_s;
  logic              first_seen_next_s;

  lfsr16 u_lfsr (
    .clk     (clk),
    .load    (lfsr_load_s),
    .seed    (SEED_EFF),
    .step    (lfsr_step_s),
    .bit_out (lfsr_bit_s)
  );

  assign last_addr_s = (addr_a_r == ADDR_LAST);
  assign exp_bit_s   = lfsr_bit_s ^ inv_r;

  // LFSR control. The LFSR is parked at the seed while idle, so the bit for
  // address 0 is already on bit_out when start arrives; data_a is registered
  // one address ahead of the write strobe. Reaching the last address reloads
  // the seed for the next phase.
  always_comb begin
    lfsr_load_s = 1'b0;
    lfsr_step_s = 1'b0;
    if (rst) begin
      lfsr_load_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            lfsr_step_s = 1'b1;
          end else begin
            lfsr_load_s = 1'b1;
          end
        end
        ST_WRITE, ST_READ: begin
          if (last_addr_s) begin
            lfsr_load_s = 1'b1;
          end else begin
            lfsr_step_s = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (TWO_PASS && !inv_r) begin
            lfsr_step_s = 1'b1;
          end else begin
            lfsr_load_s = 1'b1;
          end
        end
        default: begin
          lfsr_load_s = 1'b1;
        end
      endcase
    end
  end

  // Compare stage: q_a now belongs to the address held in the pipeline register.
  always_comb begin
    mismatch_s        = pipe_v_r && (mem.q_a != pipe_exp_r);
    err_next_s        = err_count_r;
    first_next_s      = first_err_addr_r;
    first_seen_next_s = first_seen_r;
    if (mismatch_s) begin
      if (err_count_r != ERR_MAX) begin
        err_next_s = err_count_r + ERR_ONE;
      end else begin
        err_next_s = err_count_r;
      end
      if (!first_seen_r) begin
        first_next_s      = pipe_addr_r;
        first_seen_next_s = 1'b1;
      end else begin
        first_next_s      = first_err_addr_r;
        first_seen_next_s = first_seen_r;
      end
    end else begin
      err_next_s        = err_count_r;
      first_next_s      = first_err_addr_r;
      first_seen_next_s = first_seen_r;
    end
  end

  // Controller FSM with registered memory-bus and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
      pass_r           <= 1'b0;
      err_count_r      <= ERR_ZERO;
      first_err_addr_r <= ADDR_ZERO;
      first_seen_r     <= 1'b0;
      data_a_r         <= 1'b0;
      addr_a_r         <= ADDR_ZERO;
      we_a_r           <= 1'b0;
      inv_r            <= 1'b0;
      pipe_v_r         <= 1'b0;
      pipe_exp_r       <= 1'b0;
      pipe_addr_r      <= ADDR_ZERO;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r          <= ST_WRITE;
            busy_r           <= 1'b1;
            done_r           <= 1'b0;
            pass_r           <= 1'b0;
            err_count_r      <= ERR_ZERO;
            first_err_addr_r <= ADDR_ZERO;
            first_seen_r     <= 1'b0;
            inv_r            <= 1'b0;
            addr_a_r         <= ADDR_ZERO;
            we_a_r           <= 1'b1;
            data_a_r         <= lfsr_bit_s;
            pipe_v_r         <= 1'b0;
          end
        end
        ST_WRITE: begin
          // The memory is writing addr_a_r on this edge.
          if (last_addr_s) begin
            state_r  <= ST_READ;
            we_a_r   <= 1'b0;
            data_a_r <= 1'b0;
            addr_a_r <= ADDR_ZERO;
          end else begin
            addr_a_r <= addr_a_r + ADDR_ONE;
            data_a_r <= exp_bit_s;
          end
        end
        ST_READ: begin
          // The memory captures addr_a_r on this edge; its q_a is checked next edge.
          pipe_v_r         <= 1'b1;
          pipe_exp_r       <= exp_bit_s;
          pipe_addr_r      <= addr_a_r;
          err_count_r      <= err_next_s;
          first_err_addr_r <= first_next_s;
          first_seen_r     <= first_seen_next_s;
          if (last_addr_s) begin
            state_r <= ST_DRAIN;
          end else begin
            addr_a_r <= addr_a_r + ADDR_ONE;
          end
        end
        ST_DRAIN: begin
          pipe_v_r         <= 1'b0;
          err_count_r      <= err_next_s;
          first_err_addr_r <= first_next_s;
          first_seen_r     <= first_seen_next_s;
          addr_a_r         <= ADDR_ZERO;
          if (TWO_PASS && !inv_r) begin
            state_r  <= ST_WRITE;
            inv_r    <= 1'b1;
            we_a_r   <= 1'b1;
            data_a_r <= ~lfsr_bit_s;
          end else begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            pass_r  <= (err_next_s == ERR_ZERO);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign err_count      = err_count_r;
  assign first_err_addr = first_err_addr_r;
  assign mem.data_a     = data_a_r;
  assign mem.addr_a     = addr_a_r;
  assign mem.we_a       = we_a_r;

endmodule

// File: tb/tb_lfsr_bist.sv
// tb_lfsr_bist
// Scoreboard bench for lfsr_bist. Three instances share one clock:
//   0: SEED=ACE1, single pass, ideal RAM
//   1: SEED=ACE1, two passes, RAM with injectable faults
//   2: SEED=0,    single pass, ideal RAM (must follow the SEED=1 sequence)
// Stimulus pushes expected results and expected write bits into queues;
// a negedge monitor pops and compares when the DUTs present them.
module tb_lfsr_bist;

  localparam int AW = 11;
  localparam int D  = 1 << AW;

  typedef struct {
    int   dut;
    int   cyc;
    logic pass_v;
    int   err;
    int   first;
  } res_t;

  typedef struct {
    int   dut;
    int   addr;
    logic bit_v;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst   [3];
  logic          start [3];
  logic          busy  [3];
  logic          done  [3];
  logic          pass  [3];
  logic [AW:0]   err   [3];
  logic [AW-1:0] ferr  [3];
  logic          we    [3];
  logic [AW-1:0] addr  [3];
  logic          dat   [3];
  logic          done_prev [3] = '{1'b0, 1'b0, 1'b0};

  int   cyc        = 0;
  int   start_cyc  = 0;
  int   checks     = 0;
  int   failures   = 0;
  int   stuck_addr = -1;
  int   inv_a      = -1;
  int   inv_b      = -1;
  res_t res_q[$];
  wr_t  wr_q[$];

  lfsr_bist_if #(.ADDR_W(AW)) m0 ();
  lfsr_bist_if #(.ADDR_W(AW)) m1 ();
  lfsr_bist_if #(.ADDR_W(AW)) m2 ();

  lfsr_bist #(.ADDR_W(AW), .SEED(16'hACE1), .TWO_PASS(1'b0)) dut_a (
    .clk(clk), .rst(rst[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .err_count(err[0]), .first_err_addr(ferr[0]), .mem(m0)
  );
  lfsr_bist #(.ADDR_W(AW), .SEED(16'hACE1), .TWO_PASS(1'b1)) dut_b (
    .clk(clk), .rst(rst[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .err_count(err[1]), .first_err_addr(ferr[1]), .mem(m1)
  );
  lfsr_bist #(.ADDR_W(AW), .SEED(16'h0000), .TWO_PASS(1'b0)) dut_c (
    .clk(clk), .rst(rst[2]), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .pass(pass[2]), .err_count(err[2]), .first_err_addr(ferr[2]), .mem(m2)
  );

  assign we[0] = m0.we_a;  assign addr[0] = m0.addr_a;  assign dat[0] = m0.data_a;
  assign we[1] = m1.we_a;  assign addr[1] = m1.addr_a;  assign dat[1] = m1.data_a;
  assign we[2] = m2.we_a;  assign addr[2] = m2.addr_a;  assign dat[2] = m2.data_a;

  logic ram0 [D];
  logic ram1 [D];
  logic ram2 [D];

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Ideal registered RAMs for instances 0 and 2.
  always @(posedge clk) begin
    if (m0.we_a) ram0[m0.addr_a] <= m0.data_a;
    else         m0.q_a <= ram0[m0.addr_a];
  end
  always @(posedge clk) begin
    if (m2.we_a) ram2[m2.addr_a] <= m2.data_a;
    else         m2.q_a <= ram2[m2.addr_a];
  end

  // Faulty RAM for instance 1: optional stuck-at-0 cell, two read-inverted cells.
  always @(posedge clk) begin
    if (m1.we_a) ram1[m1.addr_a] <= (int'(m1.addr_a) == stuck_addr) ? 1'b0 : m1.data_a;
    else         m1.q_a <= ram1[m1.addr_a] ^ ((int'(m1.addr_a) == inv_a) || (int'(m1.addr_a) == inv_b));
  end

  // Reference LFSR written from the tap equation.
  function automatic logic [15:0] ref_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: expected write bits and end-of-test results.
  always @(negedge clk) begin
    wr_t  w;
    res_t r;
    for (int d = 0; d < 3; d++) begin
      if (we[d] && wr_q.size() > 0) begin
        if (wr_q[0].dut == d) begin
          w = wr_q.pop_front();
          chk("wr_addr", int'(addr[d]), w.addr);
          chk("wr_data", int'(dat[d]), int'(w.bit_v));
        end
      end
      if (done[d] && !done_prev[d]) begin
        if (res_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: dut%0d raised done with no expected result", d);
        end else begin
          r = res_q.pop_front();
          chk("res_dut",   d, r.dut);
          chk("done_cycle", cyc - start_cyc + 1, r.cyc);
          chk("pass",      int'(pass[d]), int'(r.pass_v));
          chk("err_count", int'(err[d]), r.err);
          chk("first_err", int'(ferr[d]), r.first);
        end
      end
      done_prev[d] <= done[d];
    end
  end

  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int d, input int limit);
    int n = 0;
    while (!done[d] && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!done[d]) begin
      checks++;
      failures++;
      $display("FAIL wait_done: dut%0d done=0 after %0d cycles, required 1", d, limit);
    end
    @(negedge clk);
  endtask

  task automatic check_reset(input int d);
    chk("rst_busy",  int'(busy[d]), 0);
    chk("rst_done",  int'(done[d]), 0);
    chk("rst_pass",  int'(pass[d]), 0);
    chk("rst_err",   int'(err[d]),  0);
    chk("rst_ferr",  int'(ferr[d]), 0);
    chk("rst_we",    int'(we[d]),   0);
    chk("rst_addr",  int'(addr[d]), 0);
    chk("rst_data",  int'(dat[d]),  0);
  endtask

  initial begin
    logic [15:0] s;
    for (int d = 0; d < 3; d++) begin
      rst[d]   = 1'b1;
      start[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    @(negedge clk);
    check_reset(0);
    check_reset(1);
    check_reset(2);

    // Ideal run: first four written bits 1,0,1,0 from ACE1, done at 4098;
    // a start pulse during READ must not disturb anything.
    wr_q.push_back('{dut: 0, addr: 0, bit_v: 1'b1});
    wr_q.push_back('{dut: 0, addr: 1, bit_v: 1'b0});
    wr_q.push_back('{dut: 0, addr: 2, bit_v: 1'b1});
    wr_q.push_back('{dut: 0, addr: 3, bit_v: 1'b0});
    res_q.push_back('{dut: 0, cyc: 4098, pass_v: 1'b1, err: 0, first: 0});
    pulse_start(0);
    chk("busy_after_start", int'(busy[0]), 1);
    repeat (2999) @(negedge clk);
    chk("we_in_read", int'(we[0]), 0);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, 2 * D);

    // Start in DONE reruns the test.
    res_q.push_back('{dut: 0, cyc: 4098, pass_v: 1'b1, err: 0, first: 0});
    pulse_start(0);
    chk("rerun_done_low", int'(done[0]), 0);
    chk("rerun_busy",     int'(busy[0]), 1);
    wait_done(0, 2 * D + 50);

    // Reset mid-WRITE at cycle 1500, with start asserted alongside (rst wins).
    pulse_start(0);
    repeat (1499) @(negedge clk);
    rst[0]   = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    rst[0]   = 1'b0;
    start[0] = 1'b0;
    check_reset(0);
    res_q.push_back('{dut: 0, cyc: 4098, pass_v: 1'b1, err: 0, first: 0});
    pulse_start(0);
    wait_done(0, 2 * D + 50);

    // Two passes, cell 100 stuck at 0: fails in exactly one pass.
    stuck_addr = 100;
    res_q.push_back('{dut: 1, cyc: 8195, pass_v: 1'b0, err: 1, first: 100});
    pulse_start(1);
    wait_done(1, 4 * D + 50);

    // Cells 5 and 2047 read inverted: both fail in both passes. Started from
    // DONE, so the previous nonzero results must clear at once.
    stuck_addr = -1;
    inv_a      = 5;
    inv_b      = 2047;
    res_q.push_back('{dut: 1, cyc: 8195, pass_v: 1'b0, err: 4, first: 5});
    pulse_start(1);
    chk("clear_done", int'(done[1]), 0);
    chk("clear_pass", int'(pass[1]), 0);
    chk("clear_err",  int'(err[1]),  0);
    chk("clear_ferr", int'(ferr[1]), 0);
    wait_done(1, 4 * D + 50);

    // SEED=0 must write exactly the SEED=1 sequence.
    s = 16'h0001;
    for (int a = 0; a < D; a++) begin
      wr_q.push_back('{dut: 2, addr: a, bit_v: s[15]});
      s = ref_next(s);
    end
    res_q.push_back('{dut: 2, cyc: 4098, pass_v: 1'b1, err: 0, first: 0});
    pulse_start(2);
    wait_done(2, 2 * D + 50);

    chk("res_q_empty", res_q.size(), 0);
    chk("wr_q_empty",  wr_q.size(),  0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
